// File: rtl/hamming_serial_router_pkg.sv
// Shared Hamming(7,4) definitions for the serial router and its future decoder.
package hsr_pkg;

  localparam int CW_W = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Returns {p1, p2, p3}; each parity covers three of the four data bits.
  function automatic logic [2:0] hamming74_parity(input logic [3:0] d);
    return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[2] ^ d[1] ^ d[0]};
  endfunction

endpackage

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) encoder: cw = {p1, p2, d3, p3, d2, d1, d0}.
module hamming74_enc
  import hsr_pkg::*;
(
  input  logic [3:0]      i_nibble,
  output logic [CW_W-1:0] o_cw
);

  logic [2:0] w_par;

  assign w_par = hamming74_parity(i_nibble);
  assign o_cw  = {w_par[2], w_par[1], i_nibble[3], w_par[0], i_nibble[2:0]};

endmodule

// File: rtl/hamming_serial_router.sv
// Encodes a packet of nibbles and shifts the codewords MSB-first onto one
// of NUM_PORTS serial links, with a per-bit strobe and drop reporting.
module hamming_serial_router
  import hsr_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int NIBBLES   = 2,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*NIBBLES+PORT_W-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_PORTS-1:0]        port_en,
  output logic [NUM_PORTS-1:0]        data_out,
  output logic [NUM_PORTS-1:0]        strobe_out,
  output logic                        busy,
  output logic                        drop_pulse
);

  localparam int PKT_W = CW_W * NIBBLES;
  localparam int CNT_W = 4;

  state_t               r_state;
  logic [PKT_W-1:0]     r_shift;
  logic [PORT_W-1:0]    r_port;
  logic [2:0]           r_bit_cnt;
  logic [CNT_W-1:0]     r_nib_cnt;
  logic [NUM_PORTS-1:0] r_data_out;
  logic [NUM_PORTS-1:0] r_strobe_out;
  logic                 r_drop_pulse;

  logic [PKT_W-1:0]     w_cw_all;
  logic [PORT_W-1:0]    w_port;
  logic                 w_en;
  logic                 w_last;
  logic                 w_accept;
  logic [NUM_PORTS-1:0] w_sel_new;
  logic [NUM_PORTS-1:0] w_sel_cur;

  // nibble[NIBBLES-1] lands in the top codeword so it leaves first.
  for (genvar g = 0; g < NIBBLES; g++) begin : g_enc
    hamming74_enc u_enc (
      .i_nibble (in_data[4*g +: 4]),
      .o_cw     (w_cw_all[CW_W*g +: CW_W])
    );
  end

  assign w_port    = in_data[4*NIBBLES +: PORT_W];
  assign w_en      = port_en[w_port];
  assign w_sel_new = {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_port;
  assign w_sel_cur = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_port;
  assign w_last    = (r_state == SEND) && (r_bit_cnt == 3'd6) &&
                     (r_nib_cnt == CNT_W'(NIBBLES - 1));
  assign in_ready  = (r_state == IDLE) || w_last;
  assign w_accept  = in_valid && in_ready;

  assign data_out   = r_data_out;
  assign strobe_out = r_strobe_out;
  assign busy       = (r_state == SEND);
  assign drop_pulse = r_drop_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_port       <= '0;
      r_bit_cnt    <= 3'd0;
      r_nib_cnt    <= '0;
      r_data_out   <= '0;
      r_strobe_out <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= 1'b0;
      if (w_accept) begin
        // The output registers show the first bit on the cycle after accept.
        if (w_en) begin
          r_state      <= SEND;
          r_shift      <= w_cw_all;
          r_port       <= w_port;
          r_bit_cnt    <= 3'd0;
          r_nib_cnt    <= '0;
          r_data_out   <= w_sel_new & {NUM_PORTS{w_cw_all[PKT_W-1]}};
          r_strobe_out <= w_sel_new;
        end else begin
          r_state      <= IDLE;
          r_drop_pulse <= 1'b1;
          r_data_out   <= '0;
          r_strobe_out <= '0;
        end
      end else if (w_last) begin
        r_state      <= IDLE;
        r_data_out   <= '0;
        r_strobe_out <= '0;
      end else if (r_state == SEND) begin
        r_shift    <= r_shift << 1;
        r_data_out <= w_sel_cur & {NUM_PORTS{r_shift[PKT_W-2]}};
        if (r_bit_cnt == 3'd6) begin
          r_bit_cnt <= 3'd0;
          r_nib_cnt <= r_nib_cnt + 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end else begin
        r_data_out   <= '0;
        r_strobe_out <= '0;
      end
    end
  end

endmodule
